// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite memory slave.
// The state encodings are one-hot.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    WIdle  = 4'b0001,
    WHaveA = 4'b0010,
    WHaveD = 4'b0100,
    WResp  = 4'b1000
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle = 2'b01,
    RData = 2'b10
  } r_state_e;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word-organised storage with one byte-strobed write port and one registered read port.
// Contents are never reset; only the read register is.
module axi_lite_mem_array
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave in front of a small byte-strobed memory; read and write channels are
// independent FSMs, AW and W may arrive in either order.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic                S_ACLK,
  input  logic                S_ARRESET_N,
  input  logic                M_AWVALID,
  input  logic [ADDR_W-1:0]   M_AWADDR,
  output logic                S_AWREADY,
  input  logic                M_WVALID,
  input  logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W/8-1:0] M_WSTRB,
  output logic                S_WREADY,
  output logic                S_BVALID,
  output logic [1:0]          S_BRESP,
  input  logic                M_BREADY,
  input  logic                M_ARVALID,
  input  logic [ADDR_W-1:0]   M_ARADDR,
  output logic                S_ARREADY,
  output logic                S_RVALID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  input  logic                M_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WORDS  = MEM_BYTES / STRB_W;
  localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return a < LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  w_state_e            w_state_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  r_state_e            r_state_q;
  logic                arready_q, rvalid_q;
  logic [1:0]          rresp_q;

  logic                aw_hs, w_hs, ar_hs;
  logic                wr_go;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [DATA_W-1:0]   mem_rdata;

  assign aw_hs = M_AWVALID & awready_q;
  assign w_hs  = M_WVALID & wready_q;
  assign ar_hs = M_ARVALID & arready_q;

  // Pick the address/data pair that completes on this edge, from the bus or the capture regs.
  always_comb begin
    wr_go   = 1'b0;
    wr_addr = awaddr_q;
    wr_data = wdata_q;
    wr_strb = wstrb_q;
    unique case (w_state_q)
      WIdle: begin
        wr_go   = aw_hs & w_hs;
        wr_addr = M_AWADDR;
        wr_data = M_WDATA;
        wr_strb = M_WSTRB;
      end
      WHaveA: begin
        wr_go   = w_hs;
        wr_data = M_WDATA;
        wr_strb = M_WSTRB;
      end
      WHaveD: begin
        wr_go   = aw_hs;
        wr_addr = M_AWADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
    if (!S_ARRESET_N) begin
      w_state_q <= WIdle;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (w_state_q)
        WIdle, WHaveA, WHaveD: begin
          if (wr_go) begin
            w_state_q <= WResp;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
          end else if (aw_hs) begin
            w_state_q <= WHaveA;
            awready_q <= 1'b0;
            awaddr_q  <= M_AWADDR;
          end else if (w_hs) begin
            w_state_q <= WHaveD;
            wready_q  <= 1'b0;
            wdata_q   <= M_WDATA;
            wstrb_q   <= M_WSTRB;
          end
        end
        WResp: begin
          if (M_BREADY) begin
            w_state_q <= WIdle;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          w_state_q <= WIdle;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
    if (!S_ARRESET_N) begin
      r_state_q <= RIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (ar_hs) begin
            r_state_q <= RData;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= in_range(M_ARADDR) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RData: begin
          if (M_RREADY) begin
            r_state_q <= RIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          r_state_q <= RIdle;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  axi_lite_mem_array #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk    (S_ACLK),
    .rst_n  (S_ARRESET_N),
    .we     (wr_go & in_range(wr_addr)),
    .waddr  (word_idx(wr_addr)),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .re     (ar_hs),
    .raddr  (word_idx(M_ARADDR)),
    .rdata  (mem_rdata)
  );

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_ARREADY = arready_q;
  assign S_RVALID  = rvalid_q;
  assign S_RRESP   = rresp_q;
  // Error reads return zero; the array register only moves on an AR handshake, so this is stable.
  assign S_RDATA   = (rresp_q == RESP_OKAY) ? mem_rdata : '0;

endmodule
